// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the pipeline hazard logic.
//   regbits_t : 5-bit architectural register index ($0 is hard-wired zero)
//   hzstate_t : hazard FSM state encoding (RUN, MEM_WAIT, LU_STALL, HALTED)
//   fwd_t     : EX operand source select
//   src_match : true when a non-zero destination feeds a decode-stage source
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2,
        HALTED   = 2'd3
    } hzstate_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_t;

    // $0 never creates a dependency, so a zero destination never matches.
    function automatic logic src_match(input regbits_t dest, input regbits_t rs,
                                       input regbits_t rt, input logic uses_rt);
        return (dest != '0) && ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit -- combinational EX operand bypass select.
//   ex_rs/ex_rt           : source registers of the instruction in EX
//   mem_dest/mem_RegWEN   : pending write in EX/MEM (newest, wins)
//   wb_dest/wb_RegWEN     : pending write in MEM/WB
//   fwdA/fwdB             : operand select for rs / rt
module forward_unit
    import cpu_types_pkg::*;
(
    input  regbits_t ex_rs,
    input  regbits_t ex_rt,
    input  regbits_t mem_dest,
    input  logic     mem_RegWEN,
    input  regbits_t wb_dest,
    input  logic     wb_RegWEN,
    output fwd_t     fwdA,
    output fwd_t     fwdB
);

    function automatic fwd_t pick(input regbits_t src);
        if (mem_RegWEN && (mem_dest == src) && (src != '0))
            return FWD_EXMEM;
        else if (wb_RegWEN && (wb_dest == src) && (src != '0))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign fwdA = pick(ex_rs);
    assign fwdB = pick(ex_rt);

endmodule

// File: rtl/hazard_control.sv
// hazard_control -- pipeline stall/flush/forward control for a 5-stage core.
//   CLK, RST (async, active high)
//   ihit, dhit                : fetch / data access completion
//   mem_dREN, mem_dWEN        : data request pending in EX/MEM
//   dec_*                     : IF/ID source registers
//   ex_*, mem_*, wb_*         : downstream destination / write-enable fields
//   br_taken, halt_wb         : redirect in EX, halt retired in MEM/WB
//   *_en, *_flush             : pipeline register enables and bubble inserts
//   fwdA, fwdB                : EX operand select
//   stall_cnt, state          : saturating stall counter, FSM state
// Build option: HAZARD_FORWARD_EN enables bypassing; without it every RAW
// dependency on an in-flight writer is resolved by stalling.
module hazard_control
    import cpu_types_pkg::*;
#(
    parameter int STALL_CNT_W = 16
)(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dREN,
    input  logic                   mem_dWEN,
    input  regbits_t               dec_rs,
    input  regbits_t               dec_rt,
    input  logic                   dec_uses_rt,
    input  regbits_t               ex_rs,
    input  regbits_t               ex_rt,
    input  regbits_t               ex_dest,
    input  logic                   ex_RegWEN,
    input  logic                   ex_dREN,
    input  regbits_t               mem_dest,
    input  logic                   mem_RegWEN,
    input  regbits_t               wb_dest,
    input  logic                   wb_RegWEN,
    input  logic                   br_taken,
    input  logic                   halt_wb,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic [1:0]             fwdA,
    output logic [1:0]             fwdB,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             state
);

    hzstate_t cur, nxt;
    logic     data_wait, raw_stall;

    assign data_wait = (mem_dREN || mem_dWEN) && !dhit;

`ifdef HAZARD_FORWARD_EN
    fwd_t fa, fb;
    logic unused_raw;

    forward_unit u_fwd (
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .mem_dest   (mem_dest),
        .mem_RegWEN (mem_RegWEN),
        .wb_dest    (wb_dest),
        .wb_RegWEN  (wb_RegWEN),
        .fwdA       (fa),
        .fwdB       (fb)
    );

    assign fwdA = RST ? FWD_RF : fa;
    assign fwdB = RST ? FWD_RF : fb;

    // Only a load in EX must stall. In LU_STALL the EX slot holds the bubble
    // we just inserted, so the same load is never bubbled twice.
    assign raw_stall  = ex_dREN && (cur != LU_STALL) &&
                        src_match(ex_dest, dec_rs, dec_rt, dec_uses_rt);
    assign unused_raw = ^{ex_RegWEN, mem_dest[0]};
`else
    logic unused_fwd;

    assign fwdA = FWD_RF;
    assign fwdB = FWD_RF;

    // No bypass: hold decode as long as any in-flight writer targets a source.
    assign raw_stall  = ((ex_RegWEN || ex_dREN) &&
                         src_match(ex_dest, dec_rs, dec_rt, dec_uses_rt)) ||
                        (mem_RegWEN &&
                         src_match(mem_dest, dec_rs, dec_rt, dec_uses_rt));
    assign unused_fwd = ^{ex_rs, ex_rt, wb_dest, wb_RegWEN};
`endif

    // Priority: halt > data wait > branch > load-use > fetch miss.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        nxt        = cur;
        if (RST) begin
            nxt = RUN;
        end else if (cur == HALTED || halt_wb) begin
            nxt = HALTED;
        end else if (data_wait) begin
            nxt = MEM_WAIT;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            nxt      = RUN;
            if (br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (raw_stall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                nxt        = LU_STALL;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur       <= RUN;
            stall_cnt <= '0;
        end else begin
            cur <= nxt;
            if (!pc_en && (cur != HALTED) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    localparam int CW = 4;

    typedef struct packed {
        logic       ihit, dhit, mem_dREN, mem_dWEN;
        logic [4:0] dec_rs, dec_rt;
        logic       dec_uses_rt;
        logic [4:0] ex_rs, ex_rt, ex_dest;
        logic       ex_RegWEN, ex_dREN;
        logic [4:0] mem_dest;
        logic       mem_RegWEN;
        logic [4:0] wb_dest;
        logic       wb_RegWEN, br_taken, halt_wb;
    } in_t;

    logic CLK, RST;
    in_t  stim;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0] fwdA, fwdB, state;
    logic [CW-1:0] stall_cnt;
    logic [6:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;
    int mstate, mcnt;

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    hazard_control #(.STALL_CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .ihit(stim.ihit), .dhit(stim.dhit),
        .mem_dREN(stim.mem_dREN), .mem_dWEN(stim.mem_dWEN),
        .dec_rs(stim.dec_rs), .dec_rt(stim.dec_rt), .dec_uses_rt(stim.dec_uses_rt),
        .ex_rs(stim.ex_rs), .ex_rt(stim.ex_rt), .ex_dest(stim.ex_dest),
        .ex_RegWEN(stim.ex_RegWEN), .ex_dREN(stim.ex_dREN),
        .mem_dest(stim.mem_dest), .mem_RegWEN(stim.mem_RegWEN),
        .wb_dest(stim.wb_dest), .wb_RegWEN(stim.wb_RegWEN),
        .br_taken(stim.br_taken), .halt_wb(stim.halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: decisions taken straight from the priority rules.
    function automatic bit depends(input logic [4:0] d, input in_t s);
        return d != 0 && (d == s.dec_rs || (s.dec_uses_rt && d == s.dec_rt));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input in_t s);
`ifdef HAZARD_FORWARD_EN
        if (r == 0) return 2'b00;
        if (s.mem_RegWEN && s.mem_dest == r) return 2'b01;
        if (s.wb_RegWEN && s.wb_dest == r) return 2'b10;
`endif
        return 2'b00;
    endfunction

    function automatic void model(input in_t s, input int st, output logic [6:0] c,
                                  output logic [1:0] fa, output logic [1:0] fb,
                                  output int nx);
        bit raw;
`ifdef HAZARD_FORWARD_EN
        raw = s.ex_dREN && st != 2 && depends(s.ex_dest, s);
`else
        raw = ((s.ex_dREN || s.ex_RegWEN) && depends(s.ex_dest, s)) ||
              (s.mem_RegWEN && depends(s.mem_dest, s));
`endif
        fa = fwd_sel(s.ex_rs, s);
        fb = fwd_sel(s.ex_rt, s);
        if (st == 3 || s.halt_wb) begin c = 7'b0000000; nx = 3; end
        else if ((s.mem_dREN || s.mem_dWEN) && !s.dhit) begin c = 7'b0000000; nx = 1; end
        else if (s.br_taken) begin c = 7'b1111111; nx = 0; end
        else if (raw) begin c = 7'b0011101; nx = 2; end
        else if (!s.ihit) begin c = 7'b0111110; nx = 0; end
        else begin c = 7'b1111100; nx = 0; end
    endfunction

    function automatic in_t idle();
        in_t s = '0;
        s.ihit = 1'b1;
        return s;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        stim = idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
        mstate = 0;
        mcnt = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        stim = idle();
        stim.ex_rs = 5'd5; stim.mem_dest = 5'd5; stim.mem_RegWEN = 1'b1;
        stim.br_taken = 1'b1;
        #2;
        if ({ctl, fwdA, fwdB, state} !== 13'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", {ctl, fwdA, fwdB, state}, 13'd0);
        end
        n_checks++;
        step();
        if (stall_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        n_checks++;
        RST = 1'b0;
        stim = idle();
        #2;
        if ({ctl, state} !== {7'b1111100, 2'd0}) begin
            n_fail++; $display("FAIL post_reset_run: got %b want %b", {ctl, state}, {7'b1111100, 2'd0});
        end
        n_checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        stim.ex_dREN = 1'b1; stim.ex_RegWEN = 1'b1; stim.ex_dest = 5'd3; stim.dec_rs = 5'd3;
        #2;
        if ({ctl, state} !== {7'b0011101, 2'd0}) begin
            n_fail++; $display("FAIL lu_bubble: got %b want %b", {ctl, state}, {7'b0011101, 2'd0});
        end
        n_checks++;
        step();
        stim = idle();
        stim.dec_rs = 5'd3;
        #2;
        if ({ctl, state} !== {7'b1111100, 2'd2}) begin
            n_fail++; $display("FAIL lu_stall_state: got %b want %b", {ctl, state}, {7'b1111100, 2'd2});
        end
        n_checks++;
        step();
        if (state !== 2'd0 || stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lu_return: got state %0d cnt %0d want 0/1", state, stall_cnt);
        end
        n_checks++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        stim.mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            if ({ctl, state} !== {7'b0000000, (i == 0) ? 2'd0 : 2'd1}) begin
                n_fail++; $display("FAIL mem_wait_%0d: got %b", i, {ctl, state});
            end
            n_checks++;
            step();
        end
        stim.dhit = 1'b1;
        #2;
        if ({ctl, state} !== {7'b1111100, 2'd1}) begin
            n_fail++; $display("FAIL mem_release: got %b want %b", {ctl, state}, {7'b1111100, 2'd1});
        end
        n_checks++;
        step();
        stim = idle();
        #2;
        if (state !== 2'd0 || stall_cnt !== 4'd3) begin
            n_fail++; $display("FAIL mem_wait_cnt: got state %0d cnt %0d want 0/3", state, stall_cnt);
        end
        n_checks++;
    endtask

    task automatic test_branch();
        do_reset();
        stim.br_taken = 1'b1;
        stim.ex_dREN = 1'b1; stim.ex_RegWEN = 1'b1; stim.ex_dest = 5'd3; stim.dec_rs = 5'd3;
        #2;
        if (ctl !== 7'b1111111) begin
            n_fail++; $display("FAIL branch_flush: got %b want %b", ctl, 7'b1111111);
        end
        n_checks++;
        step();
        stim = idle();
        #2;
        if (state !== 2'd0 || stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL branch_no_lu: got state %0d cnt %0d want 0/0", state, stall_cnt);
        end
        n_checks++;
    endtask

    task automatic test_ihit_miss_and_reg0();
        do_reset();
        stim.ihit = 1'b0;
        #2;
        if (ctl !== 7'b0111110) begin
            n_fail++; $display("FAIL ihit_miss: got %b want %b", ctl, 7'b0111110);
        end
        n_checks++;
        stim = idle();
        stim.ex_dREN = 1'b1; stim.ex_RegWEN = 1'b1; stim.mem_RegWEN = 1'b1;
        stim.wb_RegWEN = 1'b1; stim.dec_uses_rt = 1'b1;
        #2;
        if ({ctl, fwdA, fwdB} !== {7'b1111100, 4'b0000}) begin
            n_fail++; $display("FAIL reg0_no_hazard: got %b want %b", {ctl, fwdA, fwdB}, {7'b1111100, 4'b0});
        end
        n_checks++;
        step();
    endtask

    task automatic test_forward();
        logic [1:0] e1, e2;
`ifdef HAZARD_FORWARD_EN
        e1 = 2'b01; e2 = 2'b10;
`else
        e1 = 2'b00; e2 = 2'b00;
`endif
        do_reset();
        stim.ex_rs = 5'd5; stim.ex_rt = 5'd5;
        stim.mem_dest = 5'd5; stim.mem_RegWEN = 1'b1;
        stim.wb_dest = 5'd5; stim.wb_RegWEN = 1'b1;
        #2;
        if ({fwdA, fwdB} !== {e1, e1}) begin
            n_fail++; $display("FAIL fwd_exmem: got %b/%b want %b", fwdA, fwdB, e1);
        end
        n_checks++;
        stim.mem_dest = 5'd0;
        #2;
        if ({fwdA, fwdB} !== {e2, e2}) begin
            n_fail++; $display("FAIL fwd_memwb: got %b/%b want %b", fwdA, fwdB, e2);
        end
        n_checks++;
        step();
    endtask

    task automatic test_halt();
        do_reset();
        stim.mem_dREN = 1'b1;
        step();
        stim.halt_wb = 1'b1;
        #2;
        if ({ctl, state} !== {7'b0000000, 2'd1}) begin
            n_fail++; $display("FAIL halt_in_wait: got %b", {ctl, state});
        end
        n_checks++;
        step();
        stim = idle();
        stim.br_taken = 1'b1;
        step(); step();
        #1;
        if ({ctl, state} !== {7'b0000000, 2'd3} || stall_cnt !== 4'd2) begin
            n_fail++; $display("FAIL halted_absorb: got %b cnt %0d want %b cnt 2",
                               {ctl, state}, stall_cnt, {7'b0, 2'd3});
        end
        n_checks++;
        RST = 1'b1;
        #2;
        if (state !== 2'd0 || stall_cnt !== 4'd0) begin
            n_fail++; $display("FAIL halt_reset: got state %0d cnt %0d want 0/0", state, stall_cnt);
        end
        n_checks++;
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        stim.ex_dREN = 1'b1; stim.ex_dest = 5'd7; stim.dec_rt = 5'd7; stim.dec_uses_rt = 1'b1;
        step();
        stim = idle();
        #2;
        RST = 1'b1;
        #1;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_lu: got state %0d want 0", state);
        end
        n_checks++;
        #1;
        RST = 1'b0;
        #1;
        if ({ctl, state} !== {7'b1111100, 2'd0}) begin
            n_fail++; $display("FAIL post_mid_reset: got %b", {ctl, state});
        end
        n_checks++;
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        stim.ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 9) begin
                if (stall_cnt !== 4'd10) begin
                    n_fail++; $display("FAIL cnt_midway: got %0d want 10", stall_cnt);
                end
                n_checks++;
            end
        end
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d want 15", stall_cnt);
        end
        n_checks++;
        stim = idle();
    endtask

    task automatic test_random();
        logic [6:0] ec;
        logic [1:0] ea, eb;
        int nx;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stim = '0;
            stim.ihit        = ($urandom_range(0, 3) != 0);
            stim.dhit        = $urandom_range(0, 1);
            stim.mem_dREN    = ($urandom_range(0, 4) == 0);
            stim.mem_dWEN    = ($urandom_range(0, 6) == 0);
            stim.dec_rs      = 5'($urandom_range(0, 3));
            stim.dec_rt      = 5'($urandom_range(0, 3));
            stim.dec_uses_rt = $urandom_range(0, 1);
            stim.ex_rs       = 5'($urandom_range(0, 3));
            stim.ex_rt       = 5'($urandom_range(0, 3));
            stim.ex_dest     = 5'($urandom_range(0, 3));
            stim.ex_RegWEN   = $urandom_range(0, 1);
            stim.ex_dREN     = $urandom_range(0, 1);
            stim.mem_dest    = 5'($urandom_range(0, 3));
            stim.mem_RegWEN  = $urandom_range(0, 1);
            stim.wb_dest     = 5'($urandom_range(0, 3));
            stim.wb_RegWEN   = $urandom_range(0, 1);
            stim.br_taken    = ($urandom_range(0, 7) == 0);
            #2;
            model(stim, mstate, ec, ea, eb, nx);
            if ({ctl, fwdA, fwdB, state} !== {ec, ea, eb, 2'(mstate)}) begin
                n_fail++; $display("FAIL rand_%0d: got %b want %b", i,
                                   {ctl, fwdA, fwdB, state}, {ec, ea, eb, 2'(mstate)});
            end
            n_checks++;
            if (stall_cnt !== CW'(mcnt)) begin
                n_fail++; $display("FAIL rand_cnt_%0d: got %0d want %0d", i, stall_cnt, mcnt);
            end
            n_checks++;
            if (!ec[6] && mstate != 3 && mcnt < (1 << CW) - 1) mcnt++;
            mstate = nx;
            step();
        end
        stim = idle();
    endtask

    initial begin
        RST = 1'b1;
        stim = idle();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_ihit_miss_and_reg0();
        test_forward();
        test_halt();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
